// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port word RAM between the
// data port (0) and the fetch port (1), with registered RAM control.
module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [31:0]       req_wdata_0,
    input  logic [3:0]        req_wmask_0,
    output logic              req_ready_0,
    input  logic              req_valid_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [31:0]       req_wdata_1,
    input  logic [3:0]        req_wmask_1,
    output logic              req_ready_1,
    output logic              rsp_valid_0,
    output logic              rsp_valid_1,
    output logic [31:0]       rsp_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t     state, state_nx;
    logic       last_grant, owner, grant, fire, done;
    logic [3:0] cnt;

    always_comb begin
        grant       = (req_valid_0 && req_valid_1) ? ~last_grant : req_valid_1;
        // ready is gated by reset so every output reads 0 while reset is held
        req_ready_0 = rst_n && state == IDLE && req_valid_0 && !grant;
        req_ready_1 = rst_n && state == IDLE && req_valid_1 && grant;
        fire        = req_ready_0 || req_ready_1;
        done        = state == WAIT && cnt == 4'd1;
        mem_en      = state == ISSUE;
        state_nx    = state;
        case (state)
            IDLE:    state_nx = fire ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = done ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            mem_we      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid_0 <= done && !owner;
            rsp_valid_1 <= done && owner;
            if (fire) begin
                mem_addr   <= grant ? req_addr_1 : req_addr_0;
                mem_wdata  <= grant ? req_wdata_1 : req_wdata_0;
                mem_we     <= grant ? req_wmask_1 : req_wmask_0;
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == ISSUE)
                cnt <= 4'(LATENCY);
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
            if (done)
                rsp_rdata <= (|mem_we) ? 32'd0 : mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of three arbiter instances (LATENCY 1, 3, 4),
// each attached to its own byte-writable RAM model.
module tb_mem_arbiter;
    logic        clk, rst_n;
    logic        v0 [3], v1 [3], rdy0 [3], rdy1 [3], rv0 [3], rv1 [3], men [3];
    logic [11:0] a0 [3], a1 [3], maddr [3];
    logic [31:0] wd0 [3], wd1 [3], rdata [3], mwd [3], mrd [3];
    logic [3:0]  wm0 [3], wm1 [3], mwe [3];
    int          total = 0, bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] ram [4096];
        mem_arbiter #(.ADDR_W(12), .LATENCY(g == 0 ? 1 : g == 1 ? 3 : 4)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid_0(v0[g]), .req_addr_0(a0[g]), .req_wdata_0(wd0[g]),
            .req_wmask_0(wm0[g]), .req_ready_0(rdy0[g]),
            .req_valid_1(v1[g]), .req_addr_1(a1[g]), .req_wdata_1(wd1[g]),
            .req_wmask_1(wm1[g]), .req_ready_1(rdy1[g]),
            .rsp_valid_0(rv0[g]), .rsp_valid_1(rv1[g]), .rsp_rdata(rdata[g]),
            .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(maddr[g]),
            .mem_wdata(mwd[g]), .mem_rdata(mrd[g])
        );
        assign mrd[g] = ram[maddr[g]];
        always @(posedge clk) begin
            if (men[g])
                for (int b = 0; b < 4; b++)
                    if (mwe[g][b]) ram[maddr[g]][8*b +: 8] <= mwd[g][8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int d, input int p, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] wm, input logic [31:0] ex, input int lat);
        if (p == 1) begin
            v1[d] = 1'b1; a1[d] = a; wd1[d] = wd; wm1[d] = wm;
        end else begin
            v0[d] = 1'b1; a0[d] = a; wd0[d] = wd; wm0[d] = wm;
        end
        #1;
        chk("ready", p == 1 ? rdy1[d] : rdy0[d], 1);
        chk("ready_other", p == 1 ? rdy0[d] : rdy1[d], 0);
        tick();
        v0[d] = 1'b0;
        v1[d] = 1'b0;
        chk("issue_en", men[d], 1);
        chk("issue_addr", maddr[d], a);
        chk("issue_we", mwe[d], wm);
        chk("issue_wdata", mwd[d], wd);
        repeat (lat) begin
            tick();
            chk("wait_rsp", rv0[d] | rv1[d], 0);
            chk("wait_en", men[d], 0);
        end
        tick();
        chk("rsp_valid", p == 1 ? rv1[d] : rv0[d], 1);
        chk("rsp_other", p == 1 ? rv0[d] : rv1[d], 0);
        chk("rsp_rdata", rdata[d], ex);
        chk("rsp_en", men[d], 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            v0[d] = 0; v1[d] = 0; a0[d] = 0; a1[d] = 0;
            wd0[d] = 0; wd1[d] = 0; wm0[d] = 0; wm1[d] = 0;
        end
        v0[0] = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready", rdy0[d] | rdy1[d], 0);
            chk("rst_rsp", rv0[d] | rv1[d], 0);
            chk("rst_rdata", rdata[d], 0);
            chk("rst_en", men[d], 0);
            chk("rst_we", mwe[d], 0);
            chk("rst_addr", maddr[d], 0);
            chk("rst_wdata", mwd[d], 0);
        end
        v0[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // contention from reset: both ports held valid, grants must alternate from port 0
        v0[0] = 1; a0[0] = 12'h004; v1[0] = 1; a1[0] = 12'h010;
        #1;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            chk("ctn_excl", rdy0[0] & rdy1[0], 0);
            if (rdy0[0] | rdy1[0]) begin
                chk("ctn_order", rdy1[0], n % 2);
                n++;
            end
            if (n < 6) tick();
        end
        chk("ctn_count", n, 6);
        tick();
        v0[0] = 0;
        v1[0] = 0;
        repeat (4) tick();

        // LATENCY=1: single read on port 1, write/read, byte write
        do_req(0, 0, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1);
        do_req(0, 1, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1);
        do_req(0, 0, 12'h004, 32'h12345678, 4'hF, 32'h0, 1);
        do_req(0, 0, 12'h004, 32'h0, 4'h0, 32'h12345678, 1);
        do_req(0, 0, 12'h008, 32'h11223344, 4'hF, 32'h0, 1);
        do_req(0, 1, 12'h008, 32'h0000AB00, 4'b0010, 32'h0, 1);
        do_req(0, 0, 12'h008, 32'h0, 4'h0, 32'h1122AB44, 1);

        // LATENCY=3: response at T+5 and a new handshake accepted in that cycle
        do_req(1, 0, 12'h020, 32'hCAFEF00D, 4'hF, 32'h0, 3);
        do_req(1, 1, 12'h020, 32'h0, 4'h0, 32'hCAFEF00D, 3);
        do_req(1, 0, 12'h020, 32'h0, 4'h0, 32'hCAFEF00D, 3);

        // LATENCY=4: abort a read two cycles after ISSUE
        do_req(2, 1, 12'h030, 32'hA5A5A5A5, 4'hF, 32'h0, 4);
        do_req(2, 0, 12'h030, 32'h0, 4'h0, 32'hA5A5A5A5, 4);
        v0[2] = 1; a0[2] = 12'h030; wm0[2] = 4'h0;
        tick();
        v0[2] = 0;
        chk("abort_issue", men[2], 1);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_en", men[2], 0);
        chk("abort_we", mwe[2], 0);
        chk("abort_addr", maddr[2], 0);
        chk("abort_wdata", mwd[2], 0);
        chk("abort_rdata", rdata[2], 0);
        chk("abort_rsp", rv0[2] | rv1[2], 0);
        v0[2] = 1; v1[2] = 1; a1[2] = 12'h030;
        #1;
        chk("abort_ready", rdy0[2] | rdy1[2], 0);
        repeat (5) begin
            tick();
            chk("abort_no_rsp", rv0[2] | rv1[2], 0);
        end
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy0", rdy0[2], 1);
        chk("post_rst_rdy1", rdy1[2], 0);
        tick();
        v0[2] = 0;
        v1[2] = 0;
        repeat (5) tick();
        chk("post_rst_rsp0", rv0[2], 1);
        chk("post_rst_rsp1", rv1[2], 0);
        chk("post_rst_rdata", rdata[2], 32'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
